// File: rtl/pheap_level.sv
// One interior/leaf level of the pipelined pHeap max-heap: node storage, child-read port for the level above,
// and a single-cycle LEQ/DEQ step that hands displaced or promoted work to the level below.
package pq_pkg;
    localparam int LEVELS = 3;
    localparam int KEY_W  = 8;
    localparam int VAL_W  = 8;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [VAL_W-1:0] val;
    } kv_t;

    typedef struct packed {
        kv_t               kv;
        logic [LEVELS-1:0] cap;
        logic              active;
    } entry_t;

    localparam kv_t    KV_EMPTY    = '{key: '0, val: '0};
    localparam entry_t ENTRY_EMPTY = '{kv: KV_EMPTY, cap: '0, active: 1'b0};

    typedef enum logic {LEQ = 1'b0, DEQ = 1'b1} opcode_t;
    typedef enum logic [1:0] {DONE = 2'd0, WAIT = 2'd1, NEXT_LEVEL = 2'd2} done_t;
endpackage

module pheap_level
    import pq_pkg::*;
#(
    parameter int  LEVEL  = 2,
    parameter int  LEVELS = pq_pkg::LEVELS,
    localparam int IW     = LEVEL - 1,
    localparam int RW     = (LEVEL > 2) ? LEVEL - 2 : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  opcode_t       op_in,
    input  kv_t           kv_in,
    input  logic [IW-1:0] idx_in,
    input  logic [RW-1:0] up_raddr,
    output entry_t        up_rL,
    output entry_t        up_rR,
    output logic [IW-1:0] dn_raddr,
    input  entry_t        dn_rL,
    input  entry_t        dn_rR,
    output done_t         done,
    output logic          start_out,
    output opcode_t       op_out,
    output kv_t           kv_out,
    output logic [IW:0]   idx_out,
    output logic          busy
);
    localparam int                NODES   = 1 << IW;
    localparam bit                IS_LEAF = (LEVEL == LEVELS);
    localparam logic [LEVELS-1:0] CAP_RST = LEVELS'((1 << (LEVELS - LEVEL + 1)) - 1);

    typedef enum logic {S_IDLE = 1'b0, S_EXEC = 1'b1} state_t;

    state_t        state_q, state_d;
    opcode_t       op_q;
    kv_t           kv_q;
    logic [IW-1:0] idx_q;
    entry_t        mem_q [NODES];

    entry_t            node, child_l, child_r, wdata;
    logic [LEVELS-1:0] cap_dec, cap_inc;
    logic              child_sel, dec_next, l_wins, exec_live;
    kv_t               fwd_kv;

    // Level 2 children of the single root node are simply entries 0 and 1.
    if (IW == 1) begin : g_root_children
        logic unused_raddr;
        assign unused_raddr = ^up_raddr;
        assign up_rL = mem_q[1'b0];
        assign up_rR = mem_q[1'b1];
    end else begin : g_children
        assign up_rL = mem_q[{up_raddr, 1'b0}];
        assign up_rR = mem_q[{up_raddr, 1'b1}];
    end

    if (IS_LEAF) begin : g_leaf
        logic unused_dn;
        assign unused_dn = ^{dn_rL, dn_rR};
        assign child_l   = ENTRY_EMPTY;
        assign child_r   = ENTRY_EMPTY;
    end else begin : g_inner
        assign child_l = dn_rL;
        assign child_r = dn_rR;
    end

    assign dn_raddr = IS_LEAF ? '0 : idx_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_EXEC;
            S_EXEC:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= LEQ;
            kv_q  <= KV_EMPTY;
            idx_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            op_q  <= op_in;
            kv_q  <= kv_in;
            idx_q <= idx_in;
        end
    end

    // NOTE: the node array is reset entry by entry because each empty node must report its subtree capacity.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NODES; i++)
                mem_q[i] <= '{kv: KV_EMPTY, cap: CAP_RST, active: 1'b0};
        end else if (state_q == S_EXEC) begin
            mem_q[idx_q] <= wdata;
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    always_comb begin
        node      = mem_q[idx_q];
        cap_dec   = (node.cap == '0) ? '0 : node.cap - LEVELS'(1);
        cap_inc   = (node.cap >= CAP_RST) ? CAP_RST : node.cap + LEVELS'(1);
        wdata     = node;
        fwd_kv    = KV_EMPTY;
        child_sel = 1'b0;
        dec_next  = 1'b0;
        l_wins    = child_l.active && (!child_r.active || child_l.kv.key >= child_r.kv.key);
        if (op_q == LEQ) begin
            wdata.cap = cap_dec;
            if (!node.active) begin
                wdata.kv     = kv_q;
                wdata.active = 1'b1;
            end else begin
                if (node.kv.key < kv_q.key) begin
                    wdata.kv = kv_q;
                    fwd_kv   = node.kv;
                end else begin
                    fwd_kv   = kv_q;
                end
                dec_next = !IS_LEAF;
                if (child_l.cap != '0 && child_r.cap != '0)
                    child_sel = (child_l.kv.key > child_r.kv.key);
                else
                    child_sel = (child_l.cap == '0);
            end
        end else begin
            wdata.cap = cap_inc;
            if (!child_l.active && !child_r.active) begin
                wdata.kv     = KV_EMPTY;
                wdata.active = 1'b0;
            end else begin
                wdata.kv     = l_wins ? child_l.kv : child_r.kv;
                wdata.active = 1'b1;
                child_sel    = !l_wins;
                dec_next     = 1'b1;
            end
        end
    end

    // A reset landing mid-EXEC suppresses the handoff so level L+1 never sees a half-finished step.
    assign exec_live = (state_q == S_EXEC) && !rst;

    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = DONE;
        start_out = 1'b0;
        op_out    = LEQ;
        kv_out    = KV_EMPTY;
        idx_out   = '0;
        if (state_q == S_IDLE && start && !rst)
            done = WAIT;
        if (exec_live && dec_next) begin
            done      = NEXT_LEVEL;
            start_out = 1'b1;
            op_out    = op_q;
            kv_out    = fwd_kv;
            idx_out   = {idx_q, child_sel};
        end
    end
endmodule

// File: tb/tb_pheap_level.sv
// Directed bench for pheap_level at LEVELS=3, LEVEL=2: two nodes (reset capacity 3), leaf children modelled
// by driving dn_rL/dn_rR directly; node contents observed through the up_rL/up_rR child-read port.
module tb_pheap_level;
    import pq_pkg::*;

    logic    clk = 1'b0;
    logic    rst;
    logic    start;
    opcode_t op_in;
    kv_t     kv_in;
    logic [0:0] idx_in;
    logic [0:0] up_raddr;
    entry_t  up_rL, up_rR;
    logic [0:0] dn_raddr;
    entry_t  dn_rL, dn_rR;
    done_t   done;
    logic    start_out;
    opcode_t op_out;
    kv_t     kv_out;
    logic [1:0] idx_out;
    logic    busy;

    int n_checks = 0;
    int n_errors = 0;
    int so_cnt   = 0;
    int so_base;

    pheap_level #(.LEVEL(2), .LEVELS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .op_in(op_in), .kv_in(kv_in), .idx_in(idx_in),
        .up_raddr(up_raddr), .up_rL(up_rL), .up_rR(up_rR), .dn_raddr(dn_raddr),
        .dn_rL(dn_rL), .dn_rR(dn_rR), .done(done), .start_out(start_out), .op_out(op_out),
        .kv_out(kv_out), .idx_out(idx_out), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (start_out) so_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic entry_t ent(input logic [7:0] k, input logic [7:0] v, input logic [2:0] c, input logic a);
        return '{kv: '{key: k, val: v}, cap: c, active: a};
    endfunction

    function automatic kv_t kvv(input logic [7:0] k, input logic [7:0] v);
        return '{key: k, val: v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Leaves the DUT in EXEC, 1 time unit after the accepting edge.
    task automatic issue(input opcode_t op, input logic [7:0] k, input logic [7:0] v, input logic i);
        start  = 1'b1;
        op_in  = op;
        kv_in  = kvv(k, v);
        idx_in = i;
        tick();
        start  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op_in = LEQ; kv_in = KV_EMPTY; idx_in = '0; up_raddr = '0;
        dn_rL = ENTRY_EMPTY; dn_rR = ENTRY_EMPTY;
        tick();
        do_reset();

        // Reset state
        check("rst_upL",   64'(up_rL),     64'(ent(0, 0, 3, 0)));
        check("rst_upR",   64'(up_rR),     64'(ent(0, 0, 3, 0)));
        check("rst_done",  64'(done),      64'(DONE));
        check("rst_busy",  64'(busy),      64'(0));
        check("rst_so",    64'(start_out), 64'(0));
        check("rst_kvout", 64'(kv_out),    64'(KV_EMPTY));

        // LEQ into empty node 0
        issue(LEQ, 8'd5, 8'h55, 1'b0);
        check("leq0_done",  64'(done),      64'(DONE));
        check("leq0_so",    64'(start_out), 64'(0));
        check("leq0_busy",  64'(busy),      64'(1));
        check("leq0_prewr", 64'(up_rL),     64'(ent(0, 0, 3, 0)));
        tick();
        check("leq0_mem",   64'(up_rL),     64'(ent(5, 8'h55, 2, 1)));
        check("leq0_idle",  64'(busy),      64'(0));

        // LEQ larger key into active node: displaced 5 goes left (caps 1/1, keys tie)
        dn_rL = ent(0, 0, 1, 0); dn_rR = ent(0, 0, 1, 0);
        issue(LEQ, 8'd9, 8'h99, 1'b0);
        check("leq1_done",  64'(done),      64'(NEXT_LEVEL));
        check("leq1_so",    64'(start_out), 64'(1));
        check("leq1_op",    64'(op_out),    64'(LEQ));
        check("leq1_kv",    64'(kv_out),    64'(kvv(5, 8'h55)));
        check("leq1_idx",   64'(idx_out),   64'(0));
        tick();
        check("leq1_mem",   64'(up_rL),     64'(ent(9, 8'h99, 1, 1)));
        check("leq1_so_off", 64'(start_out), 64'(0));

        // Smaller key forwarded; only right child has room
        dn_rL = ent(0, 0, 0, 1); dn_rR = ent(0, 0, 1, 1);
        issue(LEQ, 8'd2, 8'h22, 1'b0);
        check("leq2_kv",  64'(kv_out),  64'(kvv(2, 8'h22)));
        check("leq2_idx", 64'(idx_out), 64'(1));
        tick();
        check("leq2_mem", 64'(up_rL),   64'(ent(9, 8'h99, 0, 1)));

        // Capacity already 0 stays 0; both children have room, left key larger -> right
        dn_rL = ent(5, 0, 1, 1); dn_rR = ent(4, 0, 1, 1);
        issue(LEQ, 8'd1, 8'h11, 1'b0);
        check("leq3_idx", 64'(idx_out), 64'(1));
        tick();
        check("leq3_mem", 64'(up_rL),   64'(ent(9, 8'h99, 0, 1)));

        // Equal keys: node keeps its own entry, child tie goes left
        dn_rL = ent(4, 0, 1, 1); dn_rR = ent(4, 0, 1, 1);
        issue(LEQ, 8'd9, 8'hAA, 1'b0);
        check("leq4_kv",  64'(kv_out),  64'(kvv(9, 8'hAA)));
        check("leq4_idx", 64'(idx_out), 64'(0));
        tick();
        check("leq4_mem", 64'(up_rL),   64'(ent(9, 8'h99, 0, 1)));

        // Build node 1 = {7,1,1}
        issue(LEQ, 8'd7, 8'h77, 1'b1);
        check("n1_done", 64'(done), 64'(DONE));
        tick();
        dn_rL = ent(0, 0, 1, 0); dn_rR = ent(0, 0, 1, 0);
        issue(LEQ, 8'd6, 8'h66, 1'b1);
        check("n1_kv",    64'(kv_out),   64'(kvv(6, 8'h66)));
        check("n1_idx",   64'(idx_out),  64'(2));
        check("n1_raddr", 64'(dn_raddr), 64'(1));
        tick();
        check("n1_mem",   64'(up_rR),    64'(ent(7, 8'h77, 1, 1)));

        // DEQ promotes the only active child
        dn_rL = ent(3, 8'h33, 0, 1); dn_rR = ent(8, 8'h88, 1, 0);
        issue(DEQ, 8'd0, 8'h00, 1'b1);
        check("deq1_done", 64'(done),      64'(NEXT_LEVEL));
        check("deq1_so",   64'(start_out), 64'(1));
        check("deq1_op",   64'(op_out),    64'(DEQ));
        check("deq1_kv",   64'(kv_out),    64'(KV_EMPTY));
        check("deq1_idx",  64'(idx_out),   64'(2));
        tick();
        check("deq1_mem",  64'(up_rR),     64'(ent(3, 8'h33, 2, 1)));

        // DEQ with both children inactive empties the node
        dn_rL = ent(3, 8'h33, 0, 0);
        issue(DEQ, 8'd0, 8'h00, 1'b1);
        check("deq2_done", 64'(done),      64'(DONE));
        check("deq2_so",   64'(start_out), 64'(0));
        tick();
        check("deq2_mem",  64'(up_rR),     64'(ent(0, 0, 3, 0)));

        // Capacity saturates at the reset value
        issue(DEQ, 8'd0, 8'h00, 1'b1);
        tick();
        check("deq3_sat",  64'(up_rR),     64'(ent(0, 0, 3, 0)));

        // Equal child keys: left wins
        dn_rL = ent(6, 8'h61, 1, 1); dn_rR = ent(6, 8'h62, 1, 1);
        issue(DEQ, 8'd0, 8'h00, 1'b0);
        check("deq4_idx", 64'(idx_out), 64'(0));
        tick();
        check("deq4_mem", 64'(up_rL),   64'(ent(6, 8'h61, 1, 1)));

        // Larger right child wins
        dn_rL = ent(2, 8'h21, 1, 1); dn_rR = ent(4, 8'h44, 0, 1);
        issue(DEQ, 8'd0, 8'h00, 1'b0);
        check("deq5_idx", 64'(idx_out), 64'(1));
        tick();
        check("deq5_mem", 64'(up_rL),   64'(ent(4, 8'h44, 2, 1)));

        // Start held on back-to-back cycles: second is ignored
        do_reset();
        issue(LEQ, 8'd5, 8'h55, 1'b0);
        tick();
        dn_rL = ent(0, 0, 1, 0); dn_rR = ent(0, 0, 1, 0);
        so_base = so_cnt;
        start = 1'b1; op_in = LEQ; kv_in = kvv(9, 8'h99); idx_in = 1'b0;
        tick();
        kv_in = kvv(8, 8'h88);
        tick();
        start = 1'b0;
        tick();
        tick();
        check("b2b_mem",  64'(up_rL),           64'(ent(9, 8'h99, 1, 1)));
        check("b2b_so",   64'(so_cnt - so_base), 64'(1));
        check("b2b_busy", 64'(busy),            64'(0));

        // Reset during EXEC: no write, no handoff
        do_reset();
        issue(LEQ, 8'd5, 8'h55, 1'b0);
        tick();
        so_base = so_cnt;
        issue(LEQ, 8'd9, 8'h99, 1'b0);
        rst = 1'b1;
        #1;
        check("rstx_so_now", 64'(start_out), 64'(0));
        tick();
        rst = 1'b0;
        #1;
        check("rstx_upL", 64'(up_rL),            64'(ent(0, 0, 3, 0)));
        check("rstx_upR", 64'(up_rR),            64'(ent(0, 0, 3, 0)));
        check("rstx_busy", 64'(busy),            64'(0));
        check("rstx_done", 64'(done),            64'(DONE));
        check("rstx_so",  64'(so_cnt - so_base), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
